pipe_skid_reg: RTL and testbench

//  Generic inter-stage pipeline register with valid/ready handshake and optional 2-entry skid buffer.

---
 rtl/pipe_skid_reg.sv | 115 +++++++++++
 tb/tb_pipe_skid_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and an optional 2-entry skid buffer.
// The payload is split into DATA, which holds on flush, and CTRL, which is zeroed whenever no entry is live.
module pipe_skid_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 46,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        out_count
);

  // Handshake: a transfer happens on an edge where valid & ready are both high.
  // The producer keeps its payload stable while valid is high and ready is low.

  // The state encoding equals the live-entry count, so out_count exposes the FSM state directly.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                push, pop;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_count = state_q;

  // With a skid buffer, ready depends only on registered state, so there is no out_ready -> in_ready path.
  assign in_ready = (SKID != 0) ? (state_q != FULL) : (!out_valid || out_ready);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (push && (SKID != 0)) begin
            state_d     = FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (pop) begin
            // Draining to empty zeroes ctrl so a downstream stage that ignores valid sees a bubble.
            state_d     = EMPTY;
            main_ctrl_d = '0;
          end
        end
        FULL: begin
          if (pop) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a table of directed vectors for the SKID=1 build,
// plus a hand-written sequence for the combinational-ready SKID=0 build.
module tb_pipe_skid_reg;

  localparam int DW = 64;
  localparam int CW = 46;

  logic          clk;
  logic          rst_n;
  logic          flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    out_count;

  logic          s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [DW-1:0] s0_in_data, s0_out_data;
  logic [CW-1:0] s0_in_ctrl, s0_out_ctrl;
  logic [1:0]    s0_out_count;

  int checks;
  int failures;

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .out_count(out_count)
  );

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data), .in_ctrl(s0_in_ctrl),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .out_ctrl(s0_out_ctrl), .out_count(s0_out_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_ctrl;
    logic [1:0]    exp_count;
    logic          exp_in_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [DW-1:0] mkd(input int i);
    return {32'hDA7A_0000, 32'(i)};
  endfunction

  function automatic logic [CW-1:0] mkc(input int i);
    return CW'(46'h2A00_0000_0100 + 46'(i));
  endfunction

  // Payload index di is driven; edi is the entry expected on out_* after the edge.
  task automatic add_vec(input logic fl, input logic iv, input int di, input logic orr,
                         input logic ev, input int edi, input logic [1:0] ec, input logic eir);
    vec_t v;
    v.flush        = fl;
    v.in_valid     = iv;
    v.in_data      = mkd(di);
    v.in_ctrl      = mkc(di);
    v.out_ready    = orr;
    v.exp_valid    = ev;
    v.exp_data     = mkd(edi);
    v.exp_ctrl     = ev ? mkc(edi) : '0;
    v.exp_count    = ec;
    v.exp_in_ready = eir;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    flush = 0; in_valid = 0; in_data = '0; in_ctrl = '0; out_ready = 0;
    s0_flush = 0; s0_in_valid = 0; s0_in_data = '0; s0_in_ctrl = '0; s0_out_ready = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    drive_idle();

    // Reset with a live-looking input present: nothing may be captured.
    rst_n = 0;
    in_valid = 1; in_ctrl = 46'h3FF; in_data = 64'h1234;
    s0_in_valid = 1; s0_in_ctrl = 46'h3FF; s0_in_data = 64'h1234;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_s0_out_valid", 64'(s0_out_valid), 64'd0);
    chk("rst_s0_out_ctrl", 64'(s0_out_ctrl), 64'd0);
    @(negedge clk);
    drive_idle();
    rst_n = 1;

    // Streaming A..H with out_ready held high
    for (int i = 1; i <= 8; i++) add_vec(0, 1, i, 1, 1, i, 2'd1, 1);
    add_vec(0, 0, 0, 1, 0, 8, 2'd0, 1);
    // Backpressure: A,B fill, C blocked, then drained in order
    add_vec(0, 1, 10, 0, 1, 10, 2'd1, 1);
    add_vec(0, 1, 11, 0, 1, 10, 2'd2, 0);
    add_vec(0, 1, 12, 0, 1, 10, 2'd2, 0);
    add_vec(0, 1, 12, 1, 1, 11, 2'd1, 1);
    add_vec(0, 1, 12, 0, 1, 11, 2'd2, 0);
    add_vec(0, 0, 0, 1, 1, 12, 2'd1, 1);
    add_vec(0, 0, 0, 1, 0, 12, 2'd0, 1);
    // Flush while FULL with D offered: data holds A, D and the skid entry never appear
    add_vec(0, 1, 20, 0, 1, 20, 2'd1, 1);
    add_vec(0, 1, 21, 0, 1, 20, 2'd2, 0);
    add_vec(1, 1, 22, 0, 0, 20, 2'd0, 1);
    add_vec(0, 0, 0, 1, 0, 20, 2'd0, 1);
    add_vec(0, 1, 23, 1, 1, 23, 2'd1, 1);
    add_vec(0, 0, 0, 1, 0, 23, 2'd0, 1);
    // Simultaneous push and pop in ONE replaces main in place
    add_vec(0, 1, 30, 0, 1, 30, 2'd1, 1);
    add_vec(0, 1, 31, 1, 1, 31, 2'd1, 1);
    add_vec(0, 1, 32, 1, 1, 32, 2'd1, 1);
    // Flush with a pop in the same cycle still empties
    add_vec(1, 1, 33, 1, 0, 32, 2'd0, 1);

    foreach (vecs[k]) begin
      @(negedge clk);
      flush     = vecs[k].flush;
      in_valid  = vecs[k].in_valid;
      in_data   = vecs[k].in_data;
      in_ctrl   = vecs[k].in_ctrl;
      out_ready = vecs[k].out_ready;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", k), 64'(out_valid), 64'(vecs[k].exp_valid));
      chk($sformatf("v%0d_out_data", k), out_data, vecs[k].exp_data);
      chk($sformatf("v%0d_out_ctrl", k), 64'(out_ctrl), 64'(vecs[k].exp_ctrl));
      chk($sformatf("v%0d_out_count", k), 64'(out_count), 64'(vecs[k].exp_count));
      chk($sformatf("v%0d_in_ready", k), 64'(in_ready), 64'(vecs[k].exp_in_ready));
    end

    // SKID=0: combinational ready and in-place replacement
    @(negedge clk);
    s0_in_valid = 0; s0_out_ready = 0;
    #1;
    chk("s0_empty_in_ready", 64'(s0_in_ready), 64'd1);
    s0_in_valid = 1; s0_in_data = mkd(40); s0_in_ctrl = mkc(40);
    @(posedge clk);
    #1;
    chk("s0_load_valid", 64'(s0_out_valid), 64'd1);
    chk("s0_load_data", s0_out_data, mkd(40));
    chk("s0_load_count", 64'(s0_out_count), 64'd1);
    @(negedge clk);
    s0_in_data = mkd(41); s0_in_ctrl = mkc(41); s0_out_ready = 0;
    #1;
    chk("s0_stall_in_ready", 64'(s0_in_ready), 64'd0);
    s0_out_ready = 1;
    #1;
    chk("s0_go_in_ready", 64'(s0_in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("s0_replace_data", s0_out_data, mkd(41));
    chk("s0_replace_ctrl", 64'(s0_out_ctrl), 64'(mkc(41)));
    chk("s0_replace_valid", 64'(s0_out_valid), 64'd1);
    @(negedge clk);
    s0_in_valid = 0; s0_out_ready = 1;
    @(posedge clk);
    #1;
    chk("s0_drain_valid", 64'(s0_out_valid), 64'd0);
    chk("s0_drain_ctrl", 64'(s0_out_ctrl), 64'd0);
    chk("s0_drain_data", s0_out_data, mkd(41));
    @(negedge clk);
    s0_in_valid = 1; s0_in_data = mkd(42); s0_in_ctrl = mkc(42); s0_out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    s0_flush = 1; s0_in_data = mkd(43); s0_in_ctrl = mkc(43); s0_out_ready = 1;
    @(posedge clk);
    #1;
    chk("s0_flush_valid", 64'(s0_out_valid), 64'd0);
    chk("s0_flush_ctrl", 64'(s0_out_ctrl), 64'd0);
    chk("s0_flush_data", s0_out_data, mkd(42));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
